// File: rtl/ec_fp_jb_to_affine_pkg.sv
// Shared EC types/constants for the Jacobian-to-affine stage.
// FSM encodings, control width and an elaboration-time MSB helper.
package ec_fp_jb_to_affine_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXP  = 2'd1;
  localparam logic [1:0] ST_POST = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int EC_CTL_BITS = 8;
  localparam int EC_MAX_BITS = 512;

  // Index of the highest set bit (0 for v==0).
  function automatic int ec_msb(
    input logic [EC_MAX_BITS-1:0] v
  );
    int m;
    m = 0;
    for (int i = 0; i < EC_MAX_BITS; i++)
      if (v[i]) m = i;
    return m;
  endfunction

endpackage

// File: rtl/ec_fp_jb_to_affine_if.sv
// Stream bus shared by the EC stages and the mod-P multiplier.
// master drives val/sop/eop/err/mod/dat/ctl, slave drives rdy.
interface if_axi_stream #(
  parameter int DAT_BITS = 32,
  parameter int CTL_BITS = 8
);

  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic                mod;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;

  modport master (
    output val, sop, eop, err, mod, dat, ctl,
    input  rdy
  );

  modport slave (
    input  val, sop, eop, err, mod, dat, ctl,
    output rdy
  );

endinterface

// File: rtl/ec_fp_jb_to_affine_mreq.sv
// Single-outstanding multiplier requester: holds a {b,a,tag} request
// until accepted, then returns the product with a tag-mismatch flag.
module ec_fp_jb_to_affine_mreq
  import ec_fp_jb_to_affine_pkg::*;
#(
  parameter int DAT_BITS = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_go,
  input  logic [DAT_BITS-1:0]    i_a,
  input  logic [DAT_BITS-1:0]    i_b,
  input  logic [EC_CTL_BITS-1:0] i_tag,
  output logic                   o_done,
  output logic                   o_bad,
  output logic [DAT_BITS-1:0]    o_res,
  if_axi_stream.master           o_mult_if,
  if_axi_stream.slave            i_mult_if
);

  logic                   val_q, val_d;
  logic                   pend_q, pend_d;
  logic                   rdy_q;
  logic [2*DAT_BITS-1:0]  dat_q, dat_d;
  logic [EC_CTL_BITS-1:0] ctl_q, ctl_d;
  logic                   rsp_hs;
  logic                   unused_rsp;

  // Responses with nothing pending are drained and dropped.
  assign rsp_hs = i_mult_if.val && rdy_q && pend_q;

  always_comb begin
    val_d  = val_q;
    pend_d = pend_q;
    dat_d  = dat_q;
    ctl_d  = ctl_q;
    if (val_q && o_mult_if.rdy) begin
      val_d  = 1'b0;
      pend_d = 1'b1;
    end
    if (rsp_hs)
      pend_d = 1'b0;
    if (i_go) begin
      val_d = 1'b1;
      dat_d = {i_b, i_a};
      ctl_d = i_tag;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      val_q  <= 1'b0;
      pend_q <= 1'b0;
      rdy_q  <= 1'b0;
      dat_q  <= '0;
      ctl_q  <= '0;
    end else begin
      val_q  <= val_d;
      pend_q <= pend_d;
      rdy_q  <= 1'b1;
      dat_q  <= dat_d;
      ctl_q  <= ctl_d;
    end
  end

  assign o_mult_if.val = val_q;
  assign o_mult_if.dat = dat_q;
  assign o_mult_if.ctl = ctl_q;
  assign o_mult_if.sop = 1'b1;
  assign o_mult_if.eop = 1'b1;
  assign o_mult_if.err = 1'b0;
  assign o_mult_if.mod = 1'b0;
  assign i_mult_if.rdy = rdy_q;

  assign o_done = rsp_hs;
  assign o_bad  = i_mult_if.ctl[EC_CTL_BITS-1:0] != ctl_q;
  assign o_res  = i_mult_if.dat[DAT_BITS-1:0];

  assign unused_rsp = ^{i_mult_if.sop, i_mult_if.eop,
                        i_mult_if.err, i_mult_if.mod,
                        i_mult_if.dat[2*DAT_BITS-1:DAT_BITS]};

endmodule

// File: rtl/ec_fp_jb_to_affine.sv
// Jacobian (X,Y,Z) -> affine (X/Z^2, Y/Z^3) mod P, Z^-1 = Z^(P-2).
// i_p/o_p point bundles with val/rdy; o_mult_if/i_mult_if to mod-P mult.
module ec_fp_jb_to_affine
  import ec_fp_jb_to_affine_pkg::*;
#(
  parameter int                  DAT_BITS = 16,
  parameter logic [DAT_BITS-1:0] P        = DAT_BITS'(65521)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [3*DAT_BITS-1:0] i_p,
  input  logic                  i_val,
  output logic                  o_rdy,
  output logic [2*DAT_BITS-1:0] o_p,
  output logic                  o_inf,
  output logic                  o_val,
  input  logic                  i_rdy,
  output logic                  o_err,
  if_axi_stream.master          o_mult_if,
  if_axi_stream.slave           i_mult_if
);

  typedef struct packed {
    logic [DAT_BITS-1:0] x;
    logic [DAT_BITS-1:0] y;
    logic [DAT_BITS-1:0] z;
  } jb_point_t;

  typedef struct packed {
    logic [DAT_BITS-1:0] x;
    logic [DAT_BITS-1:0] y;
  } af_point_t;

  localparam logic [DAT_BITS-1:0] E = P - DAT_BITS'(2);
  localparam int EMSB = ec_msb(EC_MAX_BITS'(E));
  localparam int IW   = $clog2(DAT_BITS);
  localparam logic [IW-1:0] IDX0 =
    IW'((EMSB > 0) ? EMSB - 1 : 0);

  localparam logic [7:0] TAG_SQR = 8'd0;
  localparam logic [7:0] TAG_MUL = 8'd1;
  localparam logic [7:0] TAG_ZI2 = 8'd2;
  localparam logic [7:0] TAG_X   = 8'd3;
  localparam logic [7:0] TAG_ZI3 = 8'd4;
  localparam logic [7:0] TAG_Y   = 8'd5;

  jb_point_t           pin;
  af_point_t           pout;
  logic [1:0]          st_q, st_d;
  logic [DAT_BITS-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [DAT_BITS-1:0] acc_q, acc_d;
  logic [DAT_BITS-1:0] zi2_q, zi2_d, zi3_q, zi3_d;
  logic [DAT_BITS-1:0] px_q, px_d, py_q, py_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [1:0]          step_q, step_d;
  logic                ph_q, ph_d;
  logic                wt_q, wt_d;
  logic                inf_q, inf_d;
  logic                val_q, val_d;
  logic                err_q, err_d;
  logic                rdy_q, rdy_d;
  logic                in_hs;
  logic                go;
  logic [DAT_BITS-1:0] op_a, op_b;
  logic [7:0]          op_tag;
  logic                m_done, m_bad;
  logic [DAT_BITS-1:0] m_res;

  assign pin   = i_p;
  assign in_hs = i_val && rdy_q;

  ec_fp_jb_to_affine_mreq #(
    .DAT_BITS (DAT_BITS)
  ) u_mreq (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_go      (go),
    .i_a       (op_a),
    .i_b       (op_b),
    .i_tag     (op_tag),
    .o_done    (m_done),
    .o_bad     (m_bad),
    .o_res     (m_res),
    .o_mult_if (o_mult_if),
    .i_mult_if (i_mult_if)
  );

  // Operand select; ph_q picks the multiply half of an exponent bit.
  always_comb begin
    go     = 1'b0;
    op_a   = acc_q;
    op_b   = acc_q;
    op_tag = TAG_SQR;
    unique case (1'b1)
      st_q == ST_EXP: begin
        go = !wt_q;
        if (ph_q) begin
          op_b   = z_q;
          op_tag = TAG_MUL;
        end
      end
      st_q == ST_POST: begin
        go = !wt_q;
        unique case (step_q)
          2'd0: op_tag = TAG_ZI2;
          2'd1: begin
            op_a   = x_q;
            op_b   = zi2_q;
            op_tag = TAG_X;
          end
          2'd2: begin
            op_a   = zi2_q;
            op_tag = TAG_ZI3;
          end
          default: begin
            op_a   = y_q;
            op_b   = zi3_q;
            op_tag = TAG_Y;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    st_d   = st_q;
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    acc_d  = acc_q;
    zi2_d  = zi2_q;
    zi3_d  = zi3_q;
    px_d   = px_q;
    py_d   = py_q;
    idx_d  = idx_q;
    step_d = step_q;
    ph_d   = ph_q;
    inf_d  = inf_q;
    val_d  = val_q;
    err_d  = err_q;
    rdy_d  = 1'b0;
    wt_d   = wt_q | go;
    unique case (1'b1)
      st_q == ST_IDLE: begin
        rdy_d = !in_hs;
        if (in_hs) begin
          x_d = pin.x;
          y_d = pin.y;
          z_d = pin.z;
          if (pin.z == '0) begin
            px_d  = '0;
            py_d  = '0;
            inf_d = 1'b1;
            val_d = 1'b1;
            st_d  = ST_DONE;
          end else begin
            acc_d  = pin.z;
            idx_d  = IDX0;
            ph_d   = 1'b0;
            step_d = '0;
            // E==1 (P==3): z is its own inverse.
            st_d   = (EMSB == 0) ? ST_POST : ST_EXP;
          end
        end
      end
      st_q == ST_EXP: begin
        if (m_done) begin
          wt_d = 1'b0;
          if (m_bad) begin
            err_d = 1'b1;
            val_d = 1'b1;
            st_d  = ST_DONE;
          end else begin
            acc_d = m_res;
            if (!ph_q && E[idx_q]) begin
              ph_d = 1'b1;
            end else begin
              ph_d = 1'b0;
              if (idx_q == '0) begin
                st_d   = ST_POST;
                step_d = '0;
              end else begin
                idx_d = idx_q - 1'b1;
              end
            end
          end
        end
      end
      st_q == ST_POST: begin
        if (m_done) begin
          wt_d = 1'b0;
          if (m_bad) begin
            err_d = 1'b1;
            val_d = 1'b1;
            st_d  = ST_DONE;
          end else begin
            step_d = step_q + 2'd1;
            unique case (step_q)
              2'd0: zi2_d = m_res;
              2'd1: px_d  = m_res;
              2'd2: zi3_d = m_res;
              default: begin
                py_d  = m_res;
                val_d = 1'b1;
                st_d  = ST_DONE;
              end
            endcase
          end
        end
      end
      default: begin
        if (i_rdy) begin
          val_d = 1'b0;
          inf_d = 1'b0;
          err_d = 1'b0;
          st_d  = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st_q   <= ST_IDLE;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      acc_q  <= '0;
      zi2_q  <= '0;
      zi3_q  <= '0;
      px_q   <= '0;
      py_q   <= '0;
      idx_q  <= '0;
      step_q <= '0;
      ph_q   <= 1'b0;
      wt_q   <= 1'b0;
      inf_q  <= 1'b0;
      val_q  <= 1'b0;
      err_q  <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      acc_q  <= acc_d;
      zi2_q  <= zi2_d;
      zi3_q  <= zi3_d;
      px_q   <= px_d;
      py_q   <= py_d;
      idx_q  <= idx_d;
      step_q <= step_d;
      ph_q   <= ph_d;
      wt_q   <= wt_d;
      inf_q  <= inf_d;
      val_q  <= val_d;
      err_q  <= err_d;
      rdy_q  <= rdy_d;
    end
  end

  assign pout.x = px_q;
  assign pout.y = py_q;
  assign o_p    = pout;
  assign o_inf  = inf_q;
  assign o_val  = val_q;
  assign o_err  = err_q;
  assign o_rdy  = rdy_q;

endmodule
